ahbl_master_monitor: RTL and testbench

Synthesizable, parametrised AHB-Lite master-side protocol monitor that generalises the formal-only master assertion checker. It taps a master's AHB-Lite port passively and checks every transfer against the protocol. The checks cover HSIZE/HBURST-aware addressing, WRAP/INCRx burst length tracking, error-response exemptions and a data-phase hang timeout. Each violation is reported as a one-cycle pulse, a sticky flag and a first-fault capture, so the same block serves simulation, formal (flags asserted zero) and on-chip debug.

---
 rtl/ahbl_master_monitor_pkg.sv | 52 +++++
 rtl/ahbl_master_monitor_if.sv | 37 +++
 rtl/ahbl_master_monitor_burst_tracker.sv | 118 +++++++++++
 rtl/ahbl_master_monitor.sv | 150 +++++++++++++++
 tb/tb_ahbl_master_monitor.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ahbl_master_monitor_pkg.sv
// Shared definitions for the AHB-Lite master-side protocol monitor.
// Holds the HTRANS/HBURST encodings, the violation bit indices and the
// fixed burst-length lookup used by the burst tracker.
package ahbl_master_monitor_pkg;

  typedef enum logic [1:0] {
    TransIdle = 2'b00,
    TransBusy = 2'b01,
    TransNseq = 2'b10,
    TransSeq  = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  localparam int unsigned NumErr         = 8;
  localparam int unsigned ErrMisalign    = 0;
  localparam int unsigned ErrSize        = 1;
  localparam int unsigned ErrUnstable    = 2;
  localparam int unsigned ErrSeqOrphan   = 3;
  localparam int unsigned ErrSeqMismatch = 4;
  localparam int unsigned ErrWdata       = 5;
  localparam int unsigned ErrBurstLen    = 6;
  localparam int unsigned ErrHang        = 7;

  // Beats in a burst; 0 stands for the unbounded INCR burst.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    unique case (hburst_e'(hburst))
      BurstSingle:              len = 5'd1;
      BurstIncr:                len = 5'd0;
      BurstWrap4, BurstIncr4:   len = 5'd4;
      BurstWrap8, BurstIncr8:   len = 5'd8;
      BurstWrap16, BurstIncr16: len = 5'd16;
      default:                  len = 5'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_wrap(input logic [2:0] hburst);
    return (hburst != 3'b000) && !hburst[0];
  endfunction

endpackage

// File: rtl/ahbl_master_monitor_if.sv
// AHB-Lite bus bundle between one master and its slave side.
// master : drives the address phase and write data, sees the response.
// slave  : drives the response and read data.
// monitor: passive tap, every signal is an input.
interface ahbl_master_monitor_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  logic              hready;
  logic              hresp;
  logic              hexokay;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic              hexcl;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    input  hready, hresp, hexokay, hrdata
  );

  modport slave (
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    output hready, hresp, hexokay, hrdata
  );

  modport monitor (
    input haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    input hready, hresp, hexokay, hrdata
  );
endinterface

// File: rtl/ahbl_master_monitor_burst_tracker.sv
// Tracks the currently open AHB-Lite burst and checks SEQ/BUSY beats.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   hready_i, hresp_i            bus response
//   htrans_i, haddr_i, hwrite_i,
//   hsize_i, hburst_i            current address phase
//   seq_orphan_o                 SEQ/BUSY with no open burst
//   seq_mismatch_o               SEQ address/controls disagree with the burst
//   burst_len_o                  fixed burst overrun or cut short
module ahbl_master_monitor_burst_tracker
  import ahbl_master_monitor_pkg::*;
#(
  parameter int unsigned W_ADDR = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [1:0]        htrans_i,
  input  logic [W_ADDR-1:0] haddr_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  output logic              seq_orphan_o,
  output logic              seq_mismatch_o,
  output logic              burst_len_o
);

  logic              open_q, open_d;
  logic              fixed_q, fixed_d;
  logic              err_seen_q, err_seen_d;
  logic [4:0]        remaining_q, remaining_d;
  logic [2:0]        burst_q, burst_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [W_ADDR-1:0] prev_addr_q, prev_addr_d;

  logic              is_idle, is_busy, is_nseq, is_seq;
  logic [W_ADDR-1:0] step, incr_addr, wrap_mask, next_addr;
  logic [4:0]        new_len;

  assign is_idle = htrans_e'(htrans_i) == TransIdle;
  assign is_busy = htrans_e'(htrans_i) == TransBusy;
  assign is_nseq = htrans_e'(htrans_i) == TransNseq;
  assign is_seq  = htrans_e'(htrans_i) == TransSeq;

  // Next address uses the opening size; a changed hsize is flagged separately.
  assign step      = W_ADDR'(1) << size_q;
  assign incr_addr = prev_addr_q + step;
  assign wrap_mask = (W_ADDR'(burst_len(burst_q)) << size_q) - W_ADDR'(1);
  assign next_addr = is_wrap(burst_q) ? ((prev_addr_q & ~wrap_mask) | (incr_addr & wrap_mask))
                                      : incr_addr;
  assign new_len   = burst_len(hburst_i);

  assign seq_orphan_o   = (is_seq || is_busy) && !open_q;
  assign seq_mismatch_o = is_seq && open_q &&
                          ((haddr_i != next_addr) || (hwrite_i != write_q) ||
                           (hsize_i != size_q) || (hburst_i != burst_q));
  // An ERROR anywhere in the burst lets the master abandon it early.
  assign burst_len_o = (is_seq && open_q && fixed_q && (remaining_q == 5'd0)) ||
                       (hready_i && (is_nseq || is_idle) && open_q && fixed_q &&
                        (remaining_q != 5'd0) && !(err_seen_q || hresp_i));

  always_comb begin
    open_d      = open_q;
    fixed_d     = fixed_q;
    err_seen_d  = err_seen_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    size_d      = size_q;
    write_d     = write_q;
    prev_addr_d = prev_addr_q;
    if (hresp_i && open_q) begin
      err_seen_d = 1'b1;
    end
    if (hready_i) begin
      if (is_nseq) begin
        open_d      = 1'b1;
        fixed_d     = hburst_e'(hburst_i) != BurstIncr;
        err_seen_d  = 1'b0;
        remaining_d = (new_len != 5'd0) ? new_len - 5'd1 : 5'd0;
        burst_d     = hburst_i;
        size_d      = hsize_i;
        write_d     = hwrite_i;
        prev_addr_d = haddr_i;
      end else if (is_seq && open_q) begin
        remaining_d = (remaining_q != 5'd0) ? remaining_q - 5'd1 : 5'd0;
        prev_addr_d = haddr_i;
      end else if (is_idle) begin
        open_d     = 1'b0;
        err_seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_q      <= 1'b0;
      fixed_q     <= 1'b0;
      err_seen_q  <= 1'b0;
      remaining_q <= '0;
      burst_q     <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      open_q      <= open_d;
      fixed_q     <= fixed_d;
      err_seen_q  <= err_seen_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      size_q      <= size_d;
      write_q     <= write_d;
      prev_addr_q <= prev_addr_d;
    end
  end

endmodule

// File: rtl/ahbl_master_monitor.sv
// Passive AHB-Lite master-side protocol monitor.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         monitor tap of the master's AHB-Lite port
//   err_clr     clears sticky flags and first-fault capture
//   err_pulse   violations seen in the previous cycle
//   err_sticky  OR of all pulses since reset / err_clr
//   err_first   pulse vector of the first violating cycle
//   err_addr    haddr of the first violating cycle
module ahbl_master_monitor
  import ahbl_master_monitor_pkg::*;
#(
  parameter int unsigned W_ADDR   = 32,
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ahbl_master_monitor_if.monitor bus,
  input  logic                  err_clr,
  output logic [NumErr-1:0]     err_pulse,
  output logic [NumErr-1:0]     err_sticky,
  output logic [NumErr-1:0]     err_first,
  output logic [W_ADDR-1:0]     err_addr
);

  localparam int unsigned     WaitW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] MaxWaitC = WaitW'(MAX_WAIT);
  localparam logic [2:0]      MaxSize  = 3'($clog2(W_DATA / 8));
  localparam int unsigned     CtlW     = 15;

  logic [CtlW-1:0]   ctl, prev_ctl_q;
  logic [W_ADDR-1:0] prev_haddr_q;
  logic              prev_stall_q, prev_errfirst_q;
  logic              dphase_q, dwrite_q, wstall_q;
  logic [W_DATA-1:0] hwdata_q;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [NumErr-1:0] pulse_q, sticky_q, sticky_d, first_q, first_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [NumErr-1:0] viol;
  logic [W_ADDR-1:0] size_mask;
  logic              active, stall, hang;
  logic              seq_orphan, seq_mismatch, burst_len_err;
  logic              unused_resp;

  assign unused_resp = ^{bus.hexokay, bus.hrdata};

  assign active    = (htrans_e'(bus.htrans) == TransNseq) || (htrans_e'(bus.htrans) == TransSeq);
  assign ctl       = {bus.htrans, bus.hwrite, bus.hsize, bus.hburst, bus.hprot, bus.hmastlock,
                      bus.hexcl};
  assign size_mask = (W_ADDR'(1) << bus.hsize) - W_ADDR'(1);

  ahbl_master_monitor_burst_tracker #(
    .W_ADDR(W_ADDR)
  ) u_tracker (
    .clk_i         (clk),
    .rst_i         (rst),
    .hready_i      (bus.hready),
    .hresp_i       (bus.hresp),
    .htrans_i      (bus.htrans),
    .haddr_i       (bus.haddr),
    .hwrite_i      (bus.hwrite),
    .hsize_i       (bus.hsize),
    .hburst_i      (bus.hburst),
    .seq_orphan_o  (seq_orphan),
    .seq_mismatch_o(seq_mismatch),
    .burst_len_o   (burst_len_err)
  );

  // Wait counter: runs only while a data phase is stalled, saturates at MAX_WAIT.
  assign stall = dphase_q && !bus.hready;
  assign hang  = (MAX_WAIT != 0) && stall && (wait_q == MaxWaitC - WaitW'(1));

  always_comb begin
    wait_d = wait_q;
    if (!stall) begin
      wait_d = '0;
    end else if (wait_q < MaxWaitC) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_comb begin
    viol                 = '0;
    viol[ErrMisalign]    = active && ((bus.haddr & size_mask) != '0);
    viol[ErrSize]        = active && (bus.hsize > MaxSize);
    // The cycle after the first ERROR cycle may legally drop the pending transfer.
    viol[ErrUnstable]    = prev_stall_q && !prev_errfirst_q &&
                           ((ctl != prev_ctl_q) || (bus.haddr != prev_haddr_q));
    viol[ErrSeqOrphan]   = seq_orphan;
    viol[ErrSeqMismatch] = seq_mismatch;
    viol[ErrWdata]       = wstall_q && (bus.hwdata != hwdata_q);
    viol[ErrBurstLen]    = burst_len_err;
    viol[ErrHang]        = hang;
  end

  // A violation in the same cycle as err_clr survives it and re-arms first-fault.
  always_comb begin
    sticky_d = (err_clr ? '0 : sticky_q) | viol;
    first_d  = first_q;
    addr_d   = addr_q;
    if ((viol != '0) && ((sticky_q == '0) || err_clr)) begin
      first_d = viol;
      addr_d  = bus.haddr;
    end else if (err_clr) begin
      first_d = '0;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ctl_q      <= '0;
      prev_haddr_q    <= '0;
      prev_stall_q    <= 1'b0;
      prev_errfirst_q <= 1'b0;
      dphase_q        <= 1'b0;
      dwrite_q        <= 1'b0;
      wstall_q        <= 1'b0;
      hwdata_q        <= '0;
      wait_q          <= '0;
      pulse_q         <= '0;
      sticky_q        <= '0;
      first_q         <= '0;
      addr_q          <= '0;
    end else begin
      prev_ctl_q      <= ctl;
      prev_haddr_q    <= bus.haddr;
      prev_stall_q    <= active && !bus.hready;
      prev_errfirst_q <= bus.hresp && !bus.hready;
      if (bus.hready) begin
        dphase_q <= active;
        dwrite_q <= active && bus.hwrite;
      end
      wstall_q        <= dphase_q && dwrite_q && !bus.hready;
      hwdata_q        <= bus.hwdata;
      wait_q          <= wait_d;
      pulse_q         <= viol;
      sticky_q        <= sticky_d;
      first_q         <= first_d;
      addr_q          <= addr_d;
    end
  end

  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_first  = first_q;
  assign err_addr   = addr_q;

endmodule

// File: tb/tb_ahbl_master_monitor.sv
module tb_ahbl_master_monitor;
  import ahbl_master_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic [7:0]  err_pulse, err_sticky, err_first;
  logic [31:0] err_addr;
  int          n_checks = 0;
  int          n_errors = 0;

  ahbl_master_monitor_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  ahbl_master_monitor #(
    .W_ADDR  (32),
    .W_DATA  (32),
    .MAX_WAIT(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_first (err_first),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] trans, input logic [31:0] addr, input logic [2:0] size,
                          input logic [2:0] burst, input logic write);
    bus.htrans = trans;
    bus.haddr  = addr;
    bus.hsize  = size;
    bus.hburst = burst;
    bus.hwrite = write;
  endtask

  task automatic set_resp(input logic ready, input logic resp);
    bus.hready = ready;
    bus.hresp  = resp;
  endtask

  // Apply one cycle and check the pulse it produces one edge later.
  task automatic beat(input string tag, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [2:0] burst, input logic [7:0] exp);
    set_addr(trans, addr, 3'd2, burst, 1'b0);
    step();
    check_eq(tag, {24'd0, err_pulse}, {24'd0, exp});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    set_addr(TransIdle, 32'h0, 3'd2, BurstSingle, 1'b0);
    set_resp(1'b1, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    err_clr       = 1'b0;
    bus.hexokay   = 1'b0;
    bus.hprot     = 4'b0011;
    bus.hmastlock = 1'b0;
    bus.hexcl     = 1'b0;
    bus.hwdata    = '0;
    bus.hrdata    = '0;
    set_addr(TransIdle, 32'h0, 3'd2, BurstSingle, 1'b0);
    set_resp(1'b1, 1'b0);
    step();
    step();
    rst = 1'b0;
    check_eq("reset_pulse",  {24'd0, err_pulse},  32'h0);
    check_eq("reset_sticky", {24'd0, err_sticky}, 32'h0);
    check_eq("reset_first",  {24'd0, err_first},  32'h0);
    check_eq("reset_addr",   err_addr,            32'h0);

    // WRAP4 word burst at 0x38 wraps inside the 16-byte window.
    beat("wrap4_nseq", TransNseq, 32'h38, BurstWrap4, 8'h00);
    beat("wrap4_b1",   TransSeq,  32'h3C, BurstWrap4, 8'h00);
    beat("wrap4_b2",   TransSeq,  32'h30, BurstWrap4, 8'h00);
    beat("wrap4_b3",   TransSeq,  32'h34, BurstWrap4, 8'h00);
    beat("wrap4_idle", TransIdle, 32'h0,  BurstSingle, 8'h00);
    check_eq("wrap4_sticky", {24'd0, err_sticky}, 32'h0);
    // Linear step past the window instead of wrapping.
    beat("wrapbad_nseq", TransNseq, 32'h38, BurstWrap4, 8'h00);
    beat("wrapbad_b1",   TransSeq,  32'h3C, BurstWrap4, 8'h00);
    beat("wrapbad_b2",   TransSeq,  32'h40, BurstWrap4, 8'h10);
    check_eq("wrapbad_sticky", {24'd0, err_sticky}, 32'h10);
    check_eq("wrapbad_first",  {24'd0, err_first},  32'h10);
    check_eq("wrapbad_addr",   err_addr,            32'h40);
    pulse_reset();
    check_eq("rst_clears_sticky", {24'd0, err_sticky}, 32'h0);

    // INCR4 cut short by NSEQ, then cut short again after an ERROR.
    beat("incr4_nseq",  TransNseq, 32'h100, BurstIncr4, 8'h00);
    beat("incr4_b1",    TransSeq,  32'h104, BurstIncr4, 8'h00);
    beat("incr4_cut",   TransNseq, 32'h200, BurstIncr4, 8'h40);
    beat("incr4e_b1",   TransSeq,  32'h204, BurstIncr4, 8'h00);
    set_resp(1'b0, 1'b1);
    beat("err_cycle1",  TransSeq,  32'h208, BurstIncr4, 8'h00);
    set_resp(1'b1, 1'b1);
    beat("err_cut",     TransNseq, 32'h300, BurstIncr4, 8'h00);
    set_resp(1'b1, 1'b0);
    check_eq("incr4_sticky", {24'd0, err_sticky}, 32'h40);
    check_eq("incr4_addr",   err_addr,            32'h200);

    // IDLE cuts the open INCR4 in the same cycle as err_clr.
    err_clr = 1'b1;
    beat("clr_viol", TransIdle, 32'h50, BurstSingle, 8'h40);
    check_eq("clr_viol_sticky", {24'd0, err_sticky}, 32'h40);
    check_eq("clr_viol_first",  {24'd0, err_first},  32'h40);
    check_eq("clr_viol_addr",   err_addr,            32'h50);
    beat("clr_only", TransIdle, 32'h50, BurstSingle, 8'h00);
    check_eq("clr_only_sticky", {24'd0, err_sticky}, 32'h0);
    check_eq("clr_only_first",  {24'd0, err_first},  32'h0);
    check_eq("clr_only_addr",   err_addr,            32'h0);
    err_clr = 1'b0;

    // Pending NSEQ stalled 3 cycles, address moved on the 2nd; MAX_WAIT=2.
    beat("stall_a", TransNseq, 32'h400, BurstSingle, 8'h00);
    set_resp(1'b0, 1'b0);
    beat("stall_w1", TransNseq, 32'h404, BurstSingle, 8'h00);
    beat("stall_w2", TransNseq, 32'h408, BurstSingle, 8'h84);
    beat("stall_w3", TransNseq, 32'h408, BurstSingle, 8'h00);
    set_resp(1'b1, 1'b0);
    beat("stall_go",   TransNseq, 32'h408, BurstSingle, 8'h00);
    beat("stall_idle", TransIdle, 32'h0,   BurstSingle, 8'h00);
    check_eq("stall_sticky", {24'd0, err_sticky}, 32'h84);
    check_eq("stall_first",  {24'd0, err_first},  32'h84);
    check_eq("stall_addr",   err_addr,            32'h408);

    // Write data changing while its data phase is stalled.
    set_addr(TransNseq, 32'h500, 3'd2, BurstSingle, 1'b1);
    step();
    check_eq("wr_nseq", {24'd0, err_pulse}, 32'h0);
    set_resp(1'b0, 1'b0);
    bus.hwdata = 32'hAAAA;
    set_addr(TransIdle, 32'h0, 3'd2, BurstSingle, 1'b0);
    step();
    check_eq("wr_stall", {24'd0, err_pulse}, 32'h0);
    set_resp(1'b1, 1'b0);
    bus.hwdata = 32'hBBBB;
    step();
    check_eq("wr_change", {24'd0, err_pulse}, 32'h20);

    // Alignment and size against a 32-bit data bus.
    set_addr(TransNseq, 32'h1002, 3'd2, BurstSingle, 1'b0);
    step();
    check_eq("misalign", {24'd0, err_pulse}, 32'h01);
    set_addr(TransNseq, 32'h1002, 3'd3, BurstSingle, 1'b0);
    step();
    check_eq("misalign_size", {24'd0, err_pulse}, 32'h03);
    beat("size_idle", TransIdle, 32'h0, BurstSingle, 8'h00);

    // Reset in the middle of an INCR8 drops the burst.
    pulse_reset();
    beat("incr8_nseq", TransNseq, 32'h2000, BurstIncr8, 8'h00);
    beat("incr8_b1",   TransSeq,  32'h2004, BurstIncr8, 8'h00);
    rst = 1'b1;
    set_addr(TransSeq, 32'h2008, 3'd2, BurstIncr8, 1'b0);
    step();
    rst = 1'b0;
    check_eq("rst_mid_pulse", {24'd0, err_pulse}, 32'h0);
    beat("orphan", TransSeq, 32'h2008, BurstIncr8, 8'h08);
    check_eq("orphan_sticky", {24'd0, err_sticky}, 32'h08);
    check_eq("orphan_first",  {24'd0, err_first},  32'h08);
    check_eq("orphan_addr",   err_addr,            32'h2008);
    beat("end_idle", TransIdle, 32'h0, BurstSingle, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
